// File: rtl/bcd2binary_pkg.sv
// Shared constants for the BCD-to-binary converter: state encoding, digit limits
// and a helper for sizing the shift counter.
package bcd2binary_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StConv = ST_CONV,
        StDone = ST_DONE
    } state_e;

    localparam logic [3:0] DIG_MAX    = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;

    // Bits needed to count from 0 up to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit that picked up the shifted-in
// weight of 8 is pulled back by 3 so the digit stays decimal-weighted.
module bcd_digit_adj
    import bcd2binary_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i - ADJ_VAL;
        end
    end

endmodule

// File: rtl/bcd2binary.sv
// Sequential BCD-to-binary converter, one right shift plus digit correction per clock,
// with start/busy/valid handshake, invalid-digit flag and range check against MAX_VAL.
module bcd2binary
    import bcd2binary_pkg::*;
#(
    parameter int unsigned NDIG    = 2,
    parameter int unsigned BIN_W   = 7,
    parameter int unsigned MAX_VAL = 59
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                valid,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err,
    output logic                range_err
);

    localparam int unsigned SR_W  = 4 * NDIG + BIN_W;
    localparam int unsigned CNT_W = cnt_w(BIN_W);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MaxValW = BIN_W'(MAX_VAL);

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              err_q, err_d;
    logic              rerr_q, rerr_d;
    logic              valid_q, valid_d;

    logic [SR_W-1:0]   sr_shift;
    logic [SR_W-1:0]   sr_adj;
    logic              digit_bad;

    assign sr_shift             = sr_q >> 1;
    assign sr_adj[BIN_W-1:0]    = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (sr_shift[BIN_W+4*g +: 4]),
            .digit_o (sr_adj[BIN_W+4*g +: 4])
        );
    end

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_in[4*i +: 4] > DIG_MAX) begin
                digit_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        rerr_d  = rerr_q;
        valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    err_d   = digit_bad;
                    rerr_d  = 1'b0;
                    state_d = digit_bad ? StDone : StConv;
                end
            end
            StConv: begin
                sr_d  = sr_adj;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    bin_d   = sr_adj[BIN_W-1:0];
                    rerr_d  = (sr_adj[BIN_W-1:0] > MaxValW);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            rerr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            rerr_q  <= rerr_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == StConv);
    assign valid     = valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: directed table, hand-written corner sequences and
// random BCD bytes checked against a decimal-arithmetic reference model.
module tb_bcd2binary;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       valid;
    logic [6:0] bin_out;
    logic       err;
    logic       range_err;

    int n_vec  = 0;
    int n_fail = 0;

    int model_bin = 0;

    bcd2binary #(
        .NDIG    (2),
        .BIN_W   (7),
        .MAX_VAL (59)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .valid     (valid),
        .bin_out   (bin_out),
        .err       (err),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] bcd;
        logic       e;
        int         bin;
        logic       r;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Decimal view of the byte; bin_out is only replaced by a legal conversion.
    task automatic ref_model(input logic [7:0] b, output logic e, output int v, output logic r);
        int d0, d1;
        d0 = int'(b[3:0]);
        d1 = int'(b[7:4]);
        if (d0 > 9 || d1 > 9) begin
            e = 1'b1;
            v = model_bin;
            r = 1'b0;
        end else begin
            e = 1'b0;
            v = d1 * 10 + d0;
            r = (v > 59);
            model_bin = v;
        end
    endtask

    task automatic run_conv(input logic [7:0] b, input logic exp_e, input int exp_b,
                            input logic exp_r, input string tag);
        int lat, busy_n;
        @(negedge clk);
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!valid && lat < 30) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_e ? 1 : 7);
        check({tag, " busy cycles"}, busy_n, exp_e ? 0 : 7);
        check({tag, " busy at valid"}, int'(busy), 0);
        check({tag, " bin_out"}, int'(bin_out), exp_b);
        check({tag, " err"}, int'(err), int'(exp_e));
        check({tag, " range_err"}, int'(range_err), int'(exp_r));
        @(negedge clk);
        check({tag, " valid width"}, int'(valid), 0);
    endtask

    initial begin
        vec_t       tbl[8];
        logic       e, r;
        int         v;
        logic [7:0] b;
        int         vcount, vlat, last_v;

        tbl[0] = '{bcd: 8'h59, e: 1'b0, bin: 59, r: 1'b0};
        tbl[1] = '{bcd: 8'h3A, e: 1'b1, bin: 59, r: 1'b0};
        tbl[2] = '{bcd: 8'h99, e: 1'b0, bin: 99, r: 1'b1};
        tbl[3] = '{bcd: 8'h00, e: 1'b0, bin: 0,  r: 1'b0};
        tbl[4] = '{bcd: 8'h60, e: 1'b0, bin: 60, r: 1'b1};
        tbl[5] = '{bcd: 8'h09, e: 1'b0, bin: 9,  r: 1'b0};
        tbl[6] = '{bcd: 8'hA0, e: 1'b1, bin: 9,  r: 1'b0};
        tbl[7] = '{bcd: 8'h42, e: 1'b0, bin: 42, r: 1'b0};

        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(valid), 0);
        check("reset bin_out", int'(bin_out), 0);
        check("reset err", int'(err), 0);
        check("reset range_err", int'(range_err), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].bcd, tbl[i].e, tbl[i].bin, tbl[i].r, $sformatf("tbl%0d", i));
        end
        model_bin = 42;

        // Start pulses and bcd_in changes mid-conversion must be ignored.
        @(negedge clk);
        bcd_in = 8'h42;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        vcount = 0;
        vlat   = 0;
        for (int i = 1; i <= 16; i++) begin
            start = (i == 2 || i == 4);
            if (i == 3) bcd_in = 8'h99;
            @(negedge clk);
            if (valid) begin
                vcount++;
                vlat = i;
                check("ignore bin_out", int'(bin_out), 42);
                check("ignore range_err", int'(range_err), 0);
            end
            if (busy && valid) check("ignore busy&valid", 1, 0);
        end
        check("ignore valid count", vcount, 1);
        check("ignore latency", vlat, 7);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        bcd_in = 8'h27;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort valid", int'(valid), 0);
        check("abort bin_out", int'(bin_out), 0);
        check("abort err", int'(err), 0);
        check("abort range_err", int'(range_err), 0);
        @(negedge clk);
        rst    = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid || busy) vcount++;
        end
        check("abort no activity", vcount, 0);
        model_bin = 27;
        run_conv(8'h27, 1'b0, 27, 1'b0, "after abort");

        // Start held high: back-to-back conversions every 8 clocks.
        @(negedge clk);
        bcd_in = 8'h10;
        start  = 1'b1;
        vcount = 0;
        last_v = 0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (valid) begin
                vcount++;
                check("held bin_out", int'(bin_out), 10);
                check("held interval", i - last_v, 8);
                last_v = i;
            end
        end
        check("held valid count", vcount, 4);
        start = 1'b0;
        vcount = 0;
        while (busy && vcount < 20) begin
            @(negedge clk);
            vcount++;
        end
        repeat (2) @(negedge clk);
        model_bin = 10;

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            ref_model(b, e, v, r);
            run_conv(b, e, v, r, $sformatf("rand%0d(%02h)", i, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd2binary.md
Name: bcd2binary

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: one shift-right plus subtract-3 correction per clock. Converts packed BCD digits (e.g. keypad-entered minutes/seconds preset) into a binary count value for the timer counters. Start/busy/valid handshake, invalid-digit detection and a configurable range check against MAX_VAL.

Parameters:
NDIG, 2, number of BCD digits in bcd_in (digit 0 = ones in bits [3:0]).
BIN_W, 7, binary result width; must satisfy 2^BIN_W >= 10^NDIG (7 for NDIG=2).
MAX_VAL, 59, largest legal result; larger results flag range_err.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
start  input  1  request conversion of bcd_in; sampled only in IDLE.
bcd_in  input  4*NDIG  packed BCD value, sampled at the accepting edge.
busy  output  1  high while a conversion is in progress (CONV state).
valid  output  1  one-cycle pulse: bin_out/err/range_err are updated.
bin_out  output  BIN_W  converted binary value; holds until next successful conversion.
err  output  1  sampled bcd_in contained a digit > 9; valid with valid pulse, held until next accepted start.
range_err  output  1  result > MAX_VAL; valid with valid pulse, held until next accepted start.

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, valid=0, bin_out=0, err=0, range_err=0, shift register and counter cleared. Reset mid-conversion aborts; no valid pulse.
- States: IDLE, CONV, DONE (2-bit encoding from package).
- IDLE: on edge with start=1 (edge E0): capture bcd_in into upper 4*NDIG bits of shift register {bcd, bin} (width 4*NDIG+BIN_W, bin part zeroed), clear err/range_err, count=0.
  - If any captured digit > 9: go to DONE with err=1; bin_out unchanged.
  - Else go to CONV, busy=1.
- CONV: each edge: shift whole register right by 1, then for each digit field of bcd part: if value >= 8, subtract 3 (4-bit arithmetic, no borrow across digits). count increments; after BIN_W shifts (edge E_BIN_W) load bin_out from low BIN_W bits, set range_err = (result > MAX_VAL), busy=0, valid=1, go to IDLE. Correction after final shift is don't-care.
- DONE (error path only): valid=1 for one cycle (asserted at edge E1), then IDLE.
- Latency: success valid high in cycle following edge E_BIN_W (BIN_W clocks after accepting edge); error valid one clock after accepting edge.
- valid is exactly one cycle wide; busy and valid never both high.
- start while busy or in DONE: ignored, not queued. start held high continuously: new conversion accepted on first edge back in IDLE (i.e. edge after valid asserts).
- bcd_in changes during CONV have no effect.
- range_err does not block bin_out update; consumer decides.

Decomposition:
- Package bcd2binary_pkg: state encoding constants (ST_IDLE, ST_CONV, ST_DONE), digit constants (DIG_MAX=9, ADJ_THRESH=8, ADJ_VAL=3), counter width helper.
- Sub-module bcd_digit_adj: combinational 4-bit correction (in >= 8 ? in-3 : in), instantiated NDIG times via generate.
- Top bcd2binary: FSM, shift register, counter, digit validity check, output registers.

Test Plan:
- NDIG=2, start with bcd_in=8'h59 -> busy for 7 cycles, valid pulse 7 clocks after accept, bin_out=59 (7'b0111011), err=0, range_err=0.
- bcd_in=8'h99, MAX_VAL=59 -> bin_out=99, range_err=1, err=0; then 8'h00 -> bin_out=0, range_err cleared.
- bcd_in=8'h3A -> valid one clock after accept, err=1, bin_out retains previous value (59).
- start pulsed again at cycles 2 and 4 of a conversion of 8'h42 -> ignored, single valid with bin_out=42; bcd_in changed mid-conversion has no effect.
- Assert rst at cycle 3 of conversion of 8'h27 -> all outputs 0, IDLE, no valid; subsequent start with 8'h27 -> bin_out=27.
- start held high continuously with bcd_in=8'h10 -> back-to-back conversions, valid every 8 clocks, bin_out=10 each time.
